// File: rtl/pipe_reg_bank_pkg.sv
// Shared y86 pipeline definitions: stat codes, special icode/register IDs,
// the four inter-stage bundle layouts and the bubble value of each bundle.
package pipe_reg_bank_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  // Field order is MSB first; widths sum to 147 / 219 / 144 / 143 bits.
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        Cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_bus_t;

  localparam d_bus_t D_BUBBLE = '{stat: STAT_AOK, icode: INOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: 64'd0, valP: 64'd0};

  localparam e_bus_t E_BUBBLE = '{stat: STAT_AOK, icode: INOP, ifun: 4'h0,
                                  valC: 64'd0, valA: 64'd0, valB: 64'd0,
                                  dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

  localparam m_bus_t M_BUBBLE = '{stat: STAT_AOK, icode: INOP, Cnd: 1'b0,
                                  valE: 64'd0, valA: 64'd0, dstE: RNONE, dstM: RNONE};

  localparam w_bus_t W_BUBBLE = '{stat: STAT_AOK, icode: INOP, valE: 64'd0,
                                  valM: 64'd0, dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/pipe_reg_bank_stage.sv
// pipe_stage_reg: one pipeline register with optional stall and bubble.
//   clk, rst_n  clock / async active-low reset (loads RESET_VAL)
//   stall       hold current value (ignored when HAS_STALL = 0)
//   bubble      load BUBBLE_VAL   (ignored when HAS_BUBBLE = 0)
//   d, q        next-stage data in, registered data out
// Priority per edge: stall > bubble > load d.
module pipe_stage_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               HAS_STALL  = 1'b1,
  parameter bit               HAS_BUBBLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic hold;
  logic load_bubble;

  // Gating by the enables keeps stages without a control structurally free of it.
  assign hold        = HAS_STALL  && stall;
  assign load_bubble = HAS_BUBBLE && bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RESET_VAL;
    else if (!hold)
      q <= load_bubble ? BUBBLE_VAL : d;
  end

endmodule

// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: F/D/E/M/W pipeline registers plus condition codes.
//   clk, rst_n                   clock / async active-low reset
//   f_predPC -> F_predPC          fetch predicted PC (stall only)
//   f_D -> D, d_E -> E            decode (stall+bubble), execute (bubble only)
//   e_M -> M, m_W -> W            memory (bubble only), write-back (stall only)
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  hazard controls
//   set_cc, e_cc -> CC            {ZF,SF,OF}, loaded when set_cc
//   ctl_err                       sticky: D_stall and D_bubble seen together
module pipe_reg_bank
  import pipe_reg_bank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] f_predPC,
  output logic [63:0] F_predPC,
  input  d_bus_t      f_D,
  output d_bus_t      D,
  input  e_bus_t      d_E,
  output e_bus_t      E,
  input  m_bus_t      e_M,
  output m_bus_t      M,
  input  w_bus_t      m_W,
  output w_bus_t      W,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        E_bubble,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic        set_cc,
  input  logic [2:0]  e_cc,
  output logic [2:0]  CC,
  output logic        ctl_err
);

  localparam logic [2:0] CC_RESET = 3'b100;  // ZF=1, SF=0, OF=0

  pipe_stage_reg #(.WIDTH(64), .BUBBLE_VAL(64'd0), .RESET_VAL(64'd0),
                   .HAS_STALL(1'b1), .HAS_BUBBLE(1'b0)) u_stage_f (
    .clk(clk), .rst_n(rst_n), .stall(F_stall), .bubble(1'b0),
    .d(f_predPC), .q(F_predPC));

  pipe_stage_reg #(.WIDTH($bits(d_bus_t)), .BUBBLE_VAL(D_BUBBLE), .RESET_VAL(D_BUBBLE),
                   .HAS_STALL(1'b1), .HAS_BUBBLE(1'b1)) u_stage_d (
    .clk(clk), .rst_n(rst_n), .stall(D_stall), .bubble(D_bubble),
    .d(f_D), .q(D));

  pipe_stage_reg #(.WIDTH($bits(e_bus_t)), .BUBBLE_VAL(E_BUBBLE), .RESET_VAL(E_BUBBLE),
                   .HAS_STALL(1'b0), .HAS_BUBBLE(1'b1)) u_stage_e (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(E_bubble),
    .d(d_E), .q(E));

  pipe_stage_reg #(.WIDTH($bits(m_bus_t)), .BUBBLE_VAL(M_BUBBLE), .RESET_VAL(M_BUBBLE),
                   .HAS_STALL(1'b0), .HAS_BUBBLE(1'b1)) u_stage_m (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(M_bubble),
    .d(e_M), .q(M));

  pipe_stage_reg #(.WIDTH($bits(w_bus_t)), .BUBBLE_VAL(W_BUBBLE), .RESET_VAL(W_BUBBLE),
                   .HAS_STALL(1'b1), .HAS_BUBBLE(1'b0)) u_stage_w (
    .clk(clk), .rst_n(rst_n), .stall(W_stall), .bubble(1'b0),
    .d(m_W), .q(W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      CC <= CC_RESET;
    else if (set_cc)
      CC <= e_cc;
  end

  // D resolves a stall+bubble conflict as a stall inside its stage register;
  // this flag only records that the control block asked for both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ctl_err <= 1'b0;
    else if (D_stall && D_bubble)
      ctl_err <= 1'b1;
  end

endmodule

// File: tb/tb_pipe_reg_bank.sv
module tb_pipe_reg_bank;
  import pipe_reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_predPC, F_predPC;
  d_bus_t      f_D, D;
  e_bus_t      d_E, E;
  m_bus_t      e_M, M;
  w_bus_t      m_W, W;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic        set_cc;
  logic [2:0]  e_cc, CC;
  logic        ctl_err;

  pipe_reg_bank dut (
    .clk(clk), .rst_n(rst_n),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .f_D(f_D), .D(D), .d_E(d_E), .E(E), .e_M(e_M), .M(M), .m_W(m_W), .W(W),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .e_cc(e_cc), .CC(CC), .ctl_err(ctl_err));

  always #5 clk = ~clk;

  // Bubble values written out field by field, independent of the package constants.
  localparam d_bus_t TB_D_BUB = {3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
  localparam e_bus_t TB_E_BUB = {3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF};
  localparam m_bus_t TB_M_BUB = {3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
  localparam w_bus_t TB_W_BUB = {3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF};

  typedef struct packed {
    logic [63:0] f;
    d_bus_t      d;
    e_bus_t      e;
    m_bus_t      m;
    w_bus_t      w;
    logic [2:0]  cc;
    logic        err;
  } snap_t;

  snap_t mdl;
  snap_t expq[$];
  snap_t ex;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_data();
    logic [255:0] t;
    t = rnd256(); f_predPC = t[63:0];
    t = rnd256(); f_D = t[146:0];
    t = rnd256(); d_E = t[218:0];
    t = rnd256(); e_M = t[143:0];
    t = rnd256(); m_W = t[142:0];
    e_cc = 3'($urandom_range(0, 7));
  endtask

  task automatic clear_ctl();
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} = '0;
  endtask

  function automatic snap_t reset_snap();
    snap_t s;
    s.f = 64'd0; s.d = TB_D_BUB; s.e = TB_E_BUB; s.m = TB_M_BUB; s.w = TB_W_BUB;
    s.cc = 3'b100; s.err = 1'b0;
    return s;
  endfunction

  // Advance the reference model by one edge, queue its prediction, clock the DUT.
  task automatic step();
    snap_t n;
    n = mdl;
    if (!F_stall) n.f = f_predPC;
    if (!D_stall) n.d = D_bubble ? TB_D_BUB : f_D;
    n.e = E_bubble ? TB_E_BUB : d_E;
    n.m = M_bubble ? TB_M_BUB : e_M;
    if (!W_stall) n.w = m_W;
    if (set_cc) n.cc = e_cc;
    if (D_stall && D_bubble) n.err = 1'b1;
    mdl = n;
    expq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ctl();
    rand_data();
    F_stall = 1'b1; set_cc = 1'b1;
    #2;
    mdl = reset_snap();
    expq.push_back(mdl);
    repeat (2) @(posedge clk);
    #1;
    ex = expq.pop_front();
    n_cmp++; if (D.icode !== 4'h1) begin n_bad++; $display("FAIL reset_D_icode got=%h exp=%h", D.icode, 4'h1); end
    n_cmp++; if (E.dstM !== 4'hF) begin n_bad++; $display("FAIL reset_E_dstM got=%h exp=%h", E.dstM, 4'hF); end
    n_cmp++; if (W.stat !== 3'd1) begin n_bad++; $display("FAIL reset_W_stat got=%h exp=%h", W.stat, 3'd1); end
    n_cmp++; if (CC !== 3'b100) begin n_bad++; $display("FAIL reset_CC got=%b exp=%b", CC, 3'b100); end
    n_cmp++; if (F_predPC !== 64'd0) begin n_bad++; $display("FAIL reset_F got=%h exp=0", F_predPC); end
    n_cmp++; if ({D, E, M, W, ctl_err} !== {ex.d, ex.e, ex.m, ex.w, ex.err})
      begin n_bad++; $display("FAIL reset_all got=%h exp=%h", {D, E, M, W, ctl_err}, {ex.d, ex.e, ex.m, ex.w, ex.err}); end
    clear_ctl();
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    clear_ctl();
    rand_data();
    f_D.icode = 4'h6;
    step();
    ex = expq.pop_front();
    n_cmp++; if (D.icode !== 4'h6) begin n_bad++; $display("FAIL pass_D_icode got=%h exp=%h", D.icode, 4'h6); end
    n_cmp++; if (D !== ex.d) begin n_bad++; $display("FAIL pass_D got=%h exp=%h", D, ex.d); end
    n_cmp++; if (F_predPC !== ex.f) begin n_bad++; $display("FAIL pass_F got=%h exp=%h", F_predPC, ex.f); end
    rand_data();
    d_E.icode = 4'h6;
    step();
    ex = expq.pop_front();
    n_cmp++; if (E !== ex.e) begin n_bad++; $display("FAIL pass_E got=%h exp=%h", E, ex.e); end
    n_cmp++; if (E.icode !== 4'h6) begin n_bad++; $display("FAIL pass_E_icode got=%h exp=%h", E.icode, 4'h6); end
  endtask

  task automatic test_load_use();
    logic [63:0] f_before;
    d_bus_t      d_before;
    clear_ctl();
    rand_data();
    step();
    void'(expq.pop_front());
    f_before = mdl.f;
    d_before = mdl.d;
    rand_data();
    F_stall = 1'b1; D_stall = 1'b1; E_bubble = 1'b1;
    step();
    ex = expq.pop_front();
    n_cmp++; if (F_predPC !== f_before) begin n_bad++; $display("FAIL loaduse_F got=%h exp=%h", F_predPC, f_before); end
    n_cmp++; if (D !== d_before) begin n_bad++; $display("FAIL loaduse_D got=%h exp=%h", D, d_before); end
    n_cmp++; if (E.icode !== 4'h1) begin n_bad++; $display("FAIL loaduse_E_icode got=%h exp=%h", E.icode, 4'h1); end
    n_cmp++; if (M !== ex.m) begin n_bad++; $display("FAIL loaduse_M got=%h exp=%h", M, ex.m); end
    clear_ctl();
  endtask

  task automatic test_mispredict();
    clear_ctl();
    rand_data();
    set_cc = 1'b1; e_cc = 3'b011;
    step();
    ex = expq.pop_front();
    n_cmp++; if (CC !== 3'b011) begin n_bad++; $display("FAIL setcc_CC got=%b exp=%b", CC, 3'b011); end
    rand_data();
    set_cc = 1'b0; e_cc = 3'b100;
    D_bubble = 1'b1; E_bubble = 1'b1;
    step();
    ex = expq.pop_front();
    n_cmp++; if (D.icode !== 4'h1) begin n_bad++; $display("FAIL mispred_D_icode got=%h exp=%h", D.icode, 4'h1); end
    n_cmp++; if (E.icode !== 4'h1) begin n_bad++; $display("FAIL mispred_E_icode got=%h exp=%h", E.icode, 4'h1); end
    n_cmp++; if ({D, E} !== {ex.d, ex.e}) begin n_bad++; $display("FAIL mispred_DE got=%h exp=%h", {D, E}, {ex.d, ex.e}); end
    n_cmp++; if (CC !== 3'b011) begin n_bad++; $display("FAIL mispred_CC got=%b exp=%b", CC, 3'b011); end
    n_cmp++; if (ctl_err !== 1'b0) begin n_bad++; $display("FAIL mispred_err got=%b exp=0", ctl_err); end
    clear_ctl();
  endtask

  task automatic test_exception();
    w_bus_t w_before;
    clear_ctl();
    rand_data();
    step();
    void'(expq.pop_front());
    w_before = mdl.w;
    M_bubble = 1'b1; W_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
      ex = expq.pop_front();
      n_cmp++; if (W !== w_before) begin n_bad++; $display("FAIL exc_W_hold cyc=%0d got=%h exp=%h", i, W, w_before); end
      n_cmp++; if (M.stat !== 3'd1) begin n_bad++; $display("FAIL exc_M_stat cyc=%0d got=%h exp=%h", i, M.stat, 3'd1); end
      n_cmp++; if (M !== ex.m) begin n_bad++; $display("FAIL exc_M cyc=%0d got=%h exp=%h", i, M, ex.m); end
    end
    clear_ctl();
  endtask

  task automatic test_conflict();
    d_bus_t d_before;
    clear_ctl();
    d_before = mdl.d;
    rand_data();
    D_stall = 1'b1; D_bubble = 1'b1;
    step();
    ex = expq.pop_front();
    n_cmp++; if (D !== d_before) begin n_bad++; $display("FAIL conflict_D got=%h exp=%h", D, d_before); end
    n_cmp++; if (ctl_err !== 1'b1) begin n_bad++; $display("FAIL conflict_err got=%b exp=1", ctl_err); end
    n_cmp++; if ({F_predPC, E, M, W, CC} !== {ex.f, ex.e, ex.m, ex.w, ex.cc})
      begin n_bad++; $display("FAIL conflict_others got=%h exp=%h", {F_predPC, E, M, W, CC}, {ex.f, ex.e, ex.m, ex.w, ex.cc}); end
    clear_ctl();
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
      ex = expq.pop_front();
      n_cmp++; if (ctl_err !== ex.err) begin n_bad++; $display("FAIL conflict_sticky cyc=%0d got=%b exp=%b", i, ctl_err, ex.err); end
    end
    #2;
    rst_n = 1'b0;
    mdl = reset_snap();
    #1;
    n_cmp++; if (ctl_err !== 1'b0) begin n_bad++; $display("FAIL conflict_clear got=%b exp=0", ctl_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    clear_ctl();
    rand_data();
    step();
    void'(expq.pop_front());
    F_stall = 1'b1; W_stall = 1'b1; set_cc = 1'b1; e_cc = 3'b010;
    rand_data();
    #3;
    rst_n = 1'b0;
    mdl = reset_snap();
    expq.push_back(mdl);
    #1;
    ex = expq.pop_front();
    n_cmp++; if ({F_predPC, D, E, M, W, CC, ctl_err} !== ex)
      begin n_bad++; $display("FAIL midstall_reset got=%h exp=%h", {F_predPC, D, E, M, W, CC, ctl_err}, ex); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_data();
    step();
    ex = expq.pop_front();
    n_cmp++; if (F_predPC !== 64'd0) begin n_bad++; $display("FAIL midstall_F got=%h exp=0", F_predPC); end
    n_cmp++; if (W !== TB_W_BUB) begin n_bad++; $display("FAIL midstall_W got=%h exp=%h", W, TB_W_BUB); end
    n_cmp++; if ({D, E, M, CC} !== {ex.d, ex.e, ex.m, ex.cc})
      begin n_bad++; $display("FAIL midstall_rest got=%h exp=%h", {D, E, M, CC}, {ex.d, ex.e, ex.m, ex.cc}); end
    clear_ctl();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      rand_data();
      F_stall  = ($urandom_range(0, 3) == 0);
      D_stall  = ($urandom_range(0, 3) == 0);
      D_bubble = ($urandom_range(0, 3) == 0);
      E_bubble = ($urandom_range(0, 3) == 0);
      M_bubble = ($urandom_range(0, 3) == 0);
      W_stall  = ($urandom_range(0, 3) == 0);
      set_cc   = ($urandom_range(0, 1) == 0);
      step();
      ex = expq.pop_front();
      n_cmp++; if (F_predPC !== ex.f) begin n_bad++; $display("FAIL rnd_F cyc=%0d got=%h exp=%h", i, F_predPC, ex.f); end
      n_cmp++; if (D !== ex.d) begin n_bad++; $display("FAIL rnd_D cyc=%0d got=%h exp=%h", i, D, ex.d); end
      n_cmp++; if (E !== ex.e) begin n_bad++; $display("FAIL rnd_E cyc=%0d got=%h exp=%h", i, E, ex.e); end
      n_cmp++; if (M !== ex.m) begin n_bad++; $display("FAIL rnd_M cyc=%0d got=%h exp=%h", i, M, ex.m); end
      n_cmp++; if (W !== ex.w) begin n_bad++; $display("FAIL rnd_W cyc=%0d got=%h exp=%h", i, W, ex.w); end
      n_cmp++; if (CC !== ex.cc) begin n_bad++; $display("FAIL rnd_CC cyc=%0d got=%b exp=%b", i, CC, ex.cc); end
      n_cmp++; if (ctl_err !== ex.err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, ctl_err, ex.err); end
    end
    clear_ctl();
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_pass_through();
    test_load_use();
    test_mispredict();
    test_exception();
    test_conflict();
    test_reset_mid_stall();
    test_random();
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
